// File: rtl/imem_load_ctrl.sv
//------------------------------------------------------------------------------
// Module  : imem_load_ctrl
// Brief   : Fetch-stage sequencer for normal execution vs. instruction-memory load.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_load_ctrl #(
  parameter int          ADDR_W        = 16,
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] BOOT_ADDR     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES  = 2,
  parameter bit          START_IN_LOAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_stall,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_write_en,
  output logic [ADDR_W-1:0] imem_write_addr,
  output logic [31:0]       imem_write_data,
  output logic              core_pc_en,
  output logic              core_flush,
  output logic              redirect_en,
  output logic [31:0]       redirect_addr,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-2:0] word_count
);

  localparam int                CNT_W      = ADDR_W - 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH_WORDS);
  localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BOOT_C     = BOOT_ADDR[ADDR_W-1:0];

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_LOAD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              done_q;
  logic              start;

  // Only a rising edge of load_req starts a load, so a request left high does not retrigger
  assign start = load_req & ~req_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    load_ready  = 1'b0;
    core_pc_en  = 1'b0;
    core_flush  = 1'b0;
    redirect_en = 1'b0;
    load_busy   = 1'b1;

    case (state_q)
      S_RUN: begin
        load_busy  = 1'b0;
        core_pc_en = ~hazard_stall;
        if (start) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 4'd0;
          addr_d      = BOOT_C;
          count_d     = '0;
          err_d       = 1'b0;
        end
      end
      S_DRAIN: begin
        core_flush = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_LOAD;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      S_LOAD: begin
        core_flush = 1'b1;
        load_ready = 1'b1;
        if (load_valid) begin
          // A full memory drops the word but still honours load_last
          if (count_q == DEPTH_C) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = load_data;
            addr_d    = addr_q + ADDR_W'(4);
            count_d   = count_q + CNT_W'(1);
          end
          if (load_last) begin
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        core_pc_en  = 1'b1;
        core_flush  = 1'b1;
        redirect_en = 1'b1;
        state_d     = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (START_IN_LOAD) begin
        state_q <= S_DRAIN;
      end else begin
        state_q <= S_RUN;
      end
      req_q       <= 1'b0;
      drain_cnt_q <= 4'd0;
      addr_q      <= BOOT_C;
      count_q     <= '0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= load_req;
      drain_cnt_q <= drain_cnt_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= (state_q == S_RELEASE);
    end
  end

  assign imem_write_en   = wr_en_q;
  assign imem_write_addr = wr_addr_q;
  assign imem_write_data = wr_data_q;
  assign redirect_addr   = redirect_en ? BOOT_ADDR : 32'h0;
  assign load_done       = done_q;
  assign load_error      = err_q;
  assign word_count      = count_q;

endmodule

`default_nettype wire
